// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and redirect squash; one-cycle capture latency.
// A load-use hazard freezes PC and IF/ID while it lasts; redirect overrides it and squashes the entry to a NOP.
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module if_id_stage (
  input  logic              clk,
  input  logic              rst,
  input  logic [`ISIZE-1:0] instr_in,
  input  logic [`ISIZE-1:0] PC_in,
  input  logic              idexe_memRead_in,
  input  logic [`ASIZE-1:0] idexe_waddr_in,
  input  logic              redirect_in,
  output logic [`ISIZE-1:0] instr_out,
  output logic [`ISIZE-1:0] PC_out,
  output logic              valid_out,
  output logic              pc_write_out,
  output logic              bubble_out,
  output logic [15:0]       stall_cnt_out,
  output logic [15:0]       flush_cnt_out
);

  logic [`ISIZE-1:0] instr_q, instr_d;
  logic [`ISIZE-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic [15:0]       flush_cnt_q, flush_cnt_d;

  logic [`ASIZE-1:0] rs, rt;
  logic              waddr_nz;
  logic              src_match;
  logic              hazard;

  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign waddr_nz  = (idexe_waddr_in != '0);
  assign src_match = (idexe_waddr_in == rs) || (idexe_waddr_in == rt);
  assign hazard    = valid_q & idexe_memRead_in & waddr_nz & src_match;

  assign pc_write_out = ~hazard | redirect_in;
  assign bubble_out   = hazard | ~valid_q | redirect_in;

  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect_in) begin
      // PC_out is left alone: a squashed entry never reaches decode, so its PC is don't-care.
      instr_d = '0;
      valid_d = 1'b0;
      if (flush_cnt_q != 16'hFFFF) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end else if (hazard) begin
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      instr_d = instr_in;
      pc_d    = PC_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign instr_out     = instr_q;
  assign PC_out        = pc_q;
  assign valid_out     = valid_q;
  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, normal capture, load-use stall, r0, redirect, saturation, mid-stall reset.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] PC_in;
  logic        idexe_memRead_in;
  logic [4:0]  idexe_waddr_in;
  logic        redirect_in;
  logic [31:0] instr_out;
  logic [31:0] PC_out;
  logic        valid_out;
  logic        pc_write_out;
  logic        bubble_out;
  logic [15:0] stall_cnt_out;
  logic [15:0] flush_cnt_out;

  int checks;
  int failures;

  if_id_stage dut (
    .clk              (clk),
    .rst              (rst),
    .instr_in         (instr_in),
    .PC_in            (PC_in),
    .idexe_memRead_in (idexe_memRead_in),
    .idexe_waddr_in   (idexe_waddr_in),
    .redirect_in      (redirect_in),
    .instr_out        (instr_out),
    .PC_out           (PC_out),
    .valid_out        (valid_out),
    .pc_write_out     (pc_write_out),
    .bubble_out       (bubble_out),
    .stall_cnt_out    (stall_cnt_out),
    .flush_cnt_out    (flush_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0x00430820: rs=2, rt=3.  0x00851020: rs=4, rt=5.
  localparam logic [31:0] INSTR_A = 32'h0043_0820;
  localparam logic [31:0] INSTR_B = 32'h0085_1020;
  localparam logic [31:0] INSTR_C = 32'h0000_0000;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    instr_in = INSTR_A;
    PC_in = 32'd4;
    idexe_memRead_in = 1'b0;
    idexe_waddr_in = 5'd0;
    redirect_in = 1'b0;
    step();
    step();

    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_stall", {16'b0, stall_cnt_out}, 32'h0);
    chk("rst_flush", {16'b0, flush_cnt_out}, 32'h0);
    chk("rst_pcw", {31'b0, pc_write_out}, 32'h1);
    chk("rst_bubble", {31'b0, bubble_out}, 32'h1);

    // First edge with rst low captures the first instruction.
    rst = 1'b0;
    step();
    chk("norm_instr", instr_out, INSTR_A);
    chk("norm_pc", PC_out, 32'd4);
    chk("norm_valid", {31'b0, valid_out}, 32'h1);
    chk("norm_bubble", {31'b0, bubble_out}, 32'h0);
    chk("norm_pcw", {31'b0, pc_write_out}, 32'h1);

    // Load in EXE writes r3, which is rt of the instruction in decode.
    idexe_memRead_in = 1'b1;
    idexe_waddr_in = 5'd3;
    instr_in = INSTR_B;
    PC_in = 32'd8;
    #1;
    chk("lu_pcw", {31'b0, pc_write_out}, 32'h0);
    chk("lu_bubble", {31'b0, bubble_out}, 32'h1);
    step();
    chk("lu_hold_instr", instr_out, INSTR_A);
    chk("lu_hold_pc", PC_out, 32'd4);
    chk("lu_stall1", {16'b0, stall_cnt_out}, 32'd1);
    idexe_memRead_in = 1'b0;
    #1;
    chk("lu_release_pcw", {31'b0, pc_write_out}, 32'h1);
    step();
    chk("lu_next_instr", instr_out, INSTR_B);
    chk("lu_next_pc", PC_out, 32'd8);
    chk("lu_stall_keep", {16'b0, stall_cnt_out}, 32'd1);

    // Load targeting r0 never stalls.
    idexe_memRead_in = 1'b1;
    idexe_waddr_in = 5'd0;
    #1;
    chk("r0_pcw", {31'b0, pc_write_out}, 32'h1);
    chk("r0_bubble", {31'b0, bubble_out}, 32'h0);

    // rs match (r4) stalls; a concurrent redirect overrides it.
    idexe_waddr_in = 5'd4;
    #1;
    chk("rs_pcw", {31'b0, pc_write_out}, 32'h0);
    redirect_in = 1'b1;
    #1;
    chk("rd_pcw", {31'b0, pc_write_out}, 32'h1);
    chk("rd_bubble", {31'b0, bubble_out}, 32'h1);
    step();
    redirect_in = 1'b0;
    #1;
    chk("rd_instr", instr_out, 32'h0);
    chk("rd_valid", {31'b0, valid_out}, 32'h0);
    chk("rd_pc_hold", PC_out, 32'd8);
    chk("rd_flush", {16'b0, flush_cnt_out}, 32'd1);
    chk("rd_stall_keep", {16'b0, stall_cnt_out}, 32'd1);
    chk("inv_pcw", {31'b0, pc_write_out}, 32'h1);
    chk("inv_bubble", {31'b0, bubble_out}, 32'h1);

    // Reload INSTR_A, then hold an rs hazard long enough to saturate.
    idexe_memRead_in = 1'b0;
    instr_in = INSTR_A;
    PC_in = 32'd12;
    step();
    chk("reload_instr", instr_out, INSTR_A);
    idexe_memRead_in = 1'b1;
    idexe_waddr_in = 5'd2;
    instr_in = INSTR_C;
    PC_in = 32'd16;
    for (int i = 0; i < 65540; i++) begin
      step();
    end
    chk("sat_stall", {16'b0, stall_cnt_out}, 32'h0000_FFFF);
    chk("sat_instr", instr_out, INSTR_A);
    chk("sat_pc", PC_out, 32'd12);
    chk("sat_pcw", {31'b0, pc_write_out}, 32'h0);

    // Reset while the hazard is still held.
    rst = 1'b1;
    step();
    chk("mrst_instr", instr_out, 32'h0);
    chk("mrst_pc", PC_out, 32'h0);
    chk("mrst_valid", {31'b0, valid_out}, 32'h0);
    chk("mrst_stall", {16'b0, stall_cnt_out}, 32'h0);
    chk("mrst_flush", {16'b0, flush_cnt_out}, 32'h0);
    chk("mrst_pcw", {31'b0, pc_write_out}, 32'h1);
    chk("mrst_bubble", {31'b0, bubble_out}, 32'h1);

    rst = 1'b0;
    idexe_memRead_in = 1'b0;
    instr_in = INSTR_B;
    PC_in = 32'd20;
    step();
    chk("post_rst_instr", instr_out, INSTR_B);
    chk("post_rst_pc", PC_out, 32'd20);
    chk("post_rst_valid", {31'b0, valid_out}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
